hours_bcd_counter: RTL and testbench

//  Hours stage of the ripple-carry timer. Sits directly downstream of the minutes-tens (mod-6) stage.

---
 rtl/hours_bcd_counter_if.sv | 23 ++
 rtl/hours_bcd_counter.sv | 76 +++++++
 tb/tb_hours_bcd_counter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/hours_bcd_counter_if.sv
// Carry, time-set and hour/day output bundle for the hours stage of the ripple-carry timer.
// The bench holds the master side and the counter holds the slave side.
interface hours_bcd_counter_if;
   logic       carry_in;
   logic       set_valid;
   logic [3:0] set_tens;
   logic [3:0] set_ones;
   logic       set_err;
   logic [3:0] hr_tens;
   logic [3:0] hr_ones;
   logic       hour_pulse;
   logic       day_pulse;

   modport master (
      output carry_in, set_valid, set_tens, set_ones,
      input  set_err, hr_tens, hr_ones, hour_pulse, day_pulse
   );

   modport slave (
      input  carry_in, set_valid, set_tens, set_ones,
      output set_err, hr_tens, hr_ones, hour_pulse, day_pulse
   );
endinterface

// File: rtl/hours_bcd_counter.sv
// Hours stage of the ripple-carry timer. It synchronises the carry from the minutes-tens stage and counts it
// in two BCD digits. It also takes a validated time-set request and emits hour and day pulses.
module hours_bcd_counter #(
   parameter int SYNC_STAGES = 2,
   parameter int WRAP_HOURS  = 24
) (
   input logic                clk,
   input logic                rst,
   hours_bcd_counter_if.slave bus
);
   localparam int               ARM_W    = $clog2(SYNC_STAGES + 2);
   localparam logic [ARM_W-1:0] ARM_INIT = ARM_W'(SYNC_STAGES + 1);
   localparam logic [3:0]       MAX_TENS = 4'((WRAP_HOURS - 1) / 10);
   localparam logic [3:0]       MAX_ONES = 4'((WRAP_HOURS - 1) % 10);
   localparam logic [7:0]       WRAP_VAL = 8'(WRAP_HOURS);

   logic [SYNC_STAGES-1:0] sync;
   logic                   prev;
   logic [ARM_W-1:0]       arm_cnt;
   logic                   s_last;
   logic                   armed;
   logic                   carry_evt;
   logic                   at_max;
   logic [7:0]             set_value;
   logic                   set_legal;
   logic                   set_load;

   assign s_last    = sync[SYNC_STAGES-1];
   assign armed     = (arm_cnt == '0);
   assign carry_evt = s_last & ~prev & armed;
   assign at_max    = (bus.hr_tens == MAX_TENS) && (bus.hr_ones == MAX_ONES);

   // Digits up to 15 keep the product below 256, so 8 bits are enough.
   assign set_value = 8'(bus.set_tens) * 8'd10 + 8'(bus.set_ones);
   assign set_legal = (bus.set_tens <= 4'd9) && (bus.set_ones <= 4'd9) && (set_value < WRAP_VAL);
   assign set_load  = bus.set_valid & set_legal;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync           <= '0;
         prev           <= 1'b0;
         arm_cnt        <= ARM_INIT;
         bus.set_err    <= 1'b0;
         bus.hour_pulse <= 1'b0;
         bus.day_pulse  <= 1'b0;
         bus.hr_tens    <= 4'd0;
         bus.hr_ones    <= 4'd0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], bus.carry_in};
         prev <= s_last;
         // The mask outlasts the synchroniser fill, so a level already high at reset never looks like an edge.
         if (!armed) begin
            arm_cnt <= arm_cnt - ARM_W'(1);
         end

         bus.set_err    <= bus.set_valid & ~set_legal;
         bus.hour_pulse <= carry_evt & ~set_load;
         bus.day_pulse  <= carry_evt & ~set_load & at_max;

         if (set_load) begin
            bus.hr_tens <= bus.set_tens;
            bus.hr_ones <= bus.set_ones;
         end else if (carry_evt) begin
            if (at_max) begin
               bus.hr_tens <= 4'd0;
               bus.hr_ones <= 4'd0;
            end else if (bus.hr_ones == 4'd9) begin
               bus.hr_tens <= bus.hr_tens + 4'd1;
               bus.hr_ones <= 4'd0;
            end else begin
               bus.hr_ones <= bus.hr_ones + 4'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_hours_bcd_counter.sv
// Bench for hours_bcd_counter: one 24-hour instance and one 12-hour instance.
// Expected pulse/error results are queued at stimulus time and popped when the DUT emits them.
module tb_hours_bcd_counter;
   localparam int SYNC_STAGES = 2;
   localparam int LEVEL_CLK   = 8;

   typedef struct {
      logic [7:0] hr;
      logic       day;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;

   exp_t       pq24[$];
   exp_t       pq12[$];
   logic [7:0] eq24[$];
   logic [7:0] eq12[$];

   hours_bcd_counter_if b24 ();
   hours_bcd_counter_if b12 ();

   hours_bcd_counter #(.SYNC_STAGES(SYNC_STAGES), .WRAP_HOURS(24)) dut24 (
      .clk (clk),
      .rst (rst),
      .bus (b24.slave)
   );

   hours_bcd_counter #(.SYNC_STAGES(SYNC_STAGES), .WRAP_HOURS(12)) dut12 (
      .clk (clk),
      .rst (rst),
      .bus (b12.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   function automatic logic [7:0] hr_of(input bit sel);
      return sel ? {b12.hr_tens, b12.hr_ones} : {b24.hr_tens, b24.hr_ones};
   endfunction

   function automatic logic pulse_of(input bit sel);
      return sel ? b12.hour_pulse : b24.hour_pulse;
   endfunction

   function automatic logic err_of(input bit sel);
      return sel ? b12.set_err : b24.set_err;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_carry(input bit sel, input logic v);
      if (sel) b12.carry_in = v;
      else     b24.carry_in = v;
   endtask

   task automatic drive_set(input bit sel, input logic v, input logic [3:0] t, input logic [3:0] o);
      if (sel) begin
         b12.set_valid = v; b12.set_tens = t; b12.set_ones = o;
      end else begin
         b24.set_valid = v; b24.set_tens = t; b24.set_ones = o;
      end
   endtask

   task automatic push_pulse(input bit sel, input logic [7:0] hr, input logic day);
      exp_t e;
      e.hr  = hr;
      e.day = day;
      if (sel) pq12.push_back(e);
      else     pq24.push_back(e);
   endtask

   task automatic push_err(input bit sel, input logic [7:0] hr);
      if (sel) eq12.push_back(hr);
      else     eq24.push_back(hr);
   endtask

   // Standalone set request; hr must be as expected on the next cycle and set_err must last one cycle.
   task automatic set_only(input string tag, input bit sel, input logic [3:0] t, input logic [3:0] o,
                           input logic [7:0] exp_hr, input bit ee);
      drive_set(sel, 1'b1, t, o);
      if (ee) push_err(sel, exp_hr);
      tick(1);
      drive_set(sel, 1'b0, 4'd0, 4'd0);
      check_eq({tag, "/hr"}, 32'(hr_of(sel)), 32'(exp_hr));
      tick(1);
      check_eq({tag, "/err_width"}, 32'(err_of(sel)), 32'd0);
   endtask

   // One full carry level cycle. An optional set request lands on the edge where the carry event is seen.
   task automatic carry_cycle(input string tag, input bit sel, input bit with_set,
                              input logic [3:0] t, input logic [3:0] o,
                              input logic [7:0] exp_hr, input bit ed, input bit ep, input bit ee);
      drive_carry(sel, 1'b1);
      if (ep) push_pulse(sel, exp_hr, ed);
      if (ee) push_err(sel, exp_hr);
      for (int i = 0; i <= SYNC_STAGES; i++) begin
         if (with_set && i == SYNC_STAGES) drive_set(sel, 1'b1, t, o);
         tick(1);
         if (with_set && i == SYNC_STAGES) drive_set(sel, 1'b0, 4'd0, 4'd0);
         check_eq({tag, "/lat"}, 32'(pulse_of(sel)), (i == SYNC_STAGES) ? 32'(ep) : 32'd0);
      end
      check_eq({tag, "/hr"}, 32'(hr_of(sel)), 32'(exp_hr));
      tick(LEVEL_CLK - SYNC_STAGES - 1);
      drive_carry(sel, 1'b0);
      tick(LEVEL_CLK);
   endtask

   always @(negedge clk) begin : mon24
      exp_t       e;
      logic [7:0] h;
      if (!rst) begin
         if (b24.hour_pulse) begin
            if (pq24.size() == 0) check_eq("unexp_pulse24", 32'(b24.hour_pulse), 32'd0);
            else begin
               e = pq24.pop_front();
               check_eq("pulse_hr24", 32'({b24.hr_tens, b24.hr_ones}), 32'(e.hr));
               check_eq("day24", 32'(b24.day_pulse), 32'(e.day));
            end
         end else if (b24.day_pulse) check_eq("day_alone24", 32'(b24.day_pulse), 32'd0);
         if (b24.set_err) begin
            if (eq24.size() == 0) check_eq("unexp_err24", 32'(b24.set_err), 32'd0);
            else begin
               h = eq24.pop_front();
               check_eq("err_hr24", 32'({b24.hr_tens, b24.hr_ones}), 32'(h));
            end
         end
      end
   end

   always @(negedge clk) begin : mon12
      exp_t       e;
      logic [7:0] h;
      if (!rst) begin
         if (b12.hour_pulse) begin
            if (pq12.size() == 0) check_eq("unexp_pulse12", 32'(b12.hour_pulse), 32'd0);
            else begin
               e = pq12.pop_front();
               check_eq("pulse_hr12", 32'({b12.hr_tens, b12.hr_ones}), 32'(e.hr));
               check_eq("day12", 32'(b12.day_pulse), 32'(e.day));
            end
         end else if (b12.day_pulse) check_eq("day_alone12", 32'(b12.day_pulse), 32'd0);
         if (b12.set_err) begin
            if (eq12.size() == 0) check_eq("unexp_err12", 32'(b12.set_err), 32'd0);
            else begin
               h = eq12.pop_front();
               check_eq("err_hr12", 32'({b12.hr_tens, b12.hr_ones}), 32'(h));
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      drive_set(1'b0, 1'b0, 4'd0, 4'd0);
      drive_set(1'b1, 1'b0, 4'd0, 4'd0);
      // Carry already high through reset must never count.
      drive_carry(1'b0, 1'b1);
      drive_carry(1'b1, 1'b1);
      tick(2);
      rst = 1'b0;
      tick(10);
      check_eq("rst/hr24", 32'(hr_of(1'b0)), 32'h00);
      check_eq("rst/hr12", 32'(hr_of(1'b1)), 32'h00);
      check_eq("rst/err24", 32'(err_of(1'b0)), 32'd0);
      check_eq("rst/err12", 32'(err_of(1'b1)), 32'd0);
      drive_carry(1'b0, 1'b0);
      drive_carry(1'b1, 1'b0);
      tick(LEVEL_CLK);

      for (int i = 1; i <= 10; i++)
         carry_cycle("count", 1'b0, 1'b0, 4'd0, 4'd0, bcd(i), 1'b0, 1'b1, 1'b0);

      set_only("set23", 1'b0, 4'd2, 4'd3, 8'h23, 1'b0);
      carry_cycle("wrap24", 1'b0, 1'b0, 4'd0, 4'd0, 8'h00, 1'b1, 1'b1, 1'b0);

      set_only("set19", 1'b0, 4'd1, 4'd9, 8'h19, 1'b0);
      set_only("bad24", 1'b0, 4'd2, 4'd4, 8'h19, 1'b1);
      set_only("bad0A", 1'b0, 4'd0, 4'hA, 8'h19, 1'b1);
      set_only("badF0", 1'b0, 4'hF, 4'd0, 8'h19, 1'b1);
      carry_cycle("roll19", 1'b0, 1'b0, 4'd0, 4'd0, 8'h20, 1'b0, 1'b1, 1'b0);

      set_only("set05a", 1'b0, 4'd0, 4'd5, 8'h05, 1'b0);
      carry_cycle("setwin", 1'b0, 1'b1, 4'd0, 4'd7, 8'h07, 1'b0, 1'b0, 1'b0);
      set_only("set05b", 1'b0, 4'd0, 4'd5, 8'h05, 1'b0);
      carry_cycle("badset", 1'b0, 1'b1, 4'd2, 4'd5, 8'h06, 1'b0, 1'b1, 1'b1);

      set_only("set17", 1'b0, 4'd1, 4'd7, 8'h17, 1'b0);
      rst = 1'b1;
      tick(1);
      check_eq("midrst/hr", 32'(hr_of(1'b0)), 32'h00);
      rst = 1'b0;
      drive_carry(1'b0, 1'b1);
      tick(LEVEL_CLK);
      check_eq("armmask/hr", 32'(hr_of(1'b0)), 32'h00);
      drive_carry(1'b0, 1'b0);
      tick(LEVEL_CLK);
      carry_cycle("rearm", 1'b0, 1'b0, 4'd0, 4'd0, 8'h01, 1'b0, 1'b1, 1'b0);

      set_only("set11", 1'b1, 4'd1, 4'd1, 8'h11, 1'b0);
      carry_cycle("wrap12", 1'b1, 1'b0, 4'd0, 4'd0, 8'h00, 1'b1, 1'b1, 1'b0);
      set_only("bad12", 1'b1, 4'd1, 4'd2, 8'h00, 1'b1);
      set_only("set09", 1'b1, 4'd0, 4'd9, 8'h09, 1'b0);
      carry_cycle("roll09", 1'b1, 1'b0, 4'd0, 4'd0, 8'h10, 1'b0, 1'b1, 1'b0);
      check_eq("idle/hr24", 32'(hr_of(1'b0)), 32'h01);

      tick(4);
      check_eq("drain/pq24", 32'(pq24.size()), 32'd0);
      check_eq("drain/pq12", 32'(pq12.size()), 32'd0);
      check_eq("drain/eq24", 32'(eq24.size()), 32'd0);
      check_eq("drain/eq12", 32'(eq12.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
